wb_sdram_arbiter: RTL and testbench

- Wishbone classic round-robin arbiter that shares the single `wb_sdram_ctrl` slave port among NUM_M requesters, for example the DSP core data port and the board button/LED test master.
- Sits between the masters and `wb_sdram_ctrl` in the SoC top and runs in the `wb_sdram_ctrl` clock domain.
- Only one transfer is outstanding at a time.
- The request is latched at grant, so the slave sees stable address, data and control until it acknowledges.

---
 rtl/wb_sdram_arb_pkg.sv | 29 ++
 rtl/wb_sdram_arbiter_rr_pick.sv | 30 +++
 rtl/wb_sdram_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sdram_arb_pkg.sv
// Shared types, defaults and helpers for the wb_sdram_ctrl master arbiter.
// Optional watchdog is enabled in the top by defining WB_SDRAM_ARB_TIMEOUT_EN.
package wb_sdram_arb_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t StIdle = 1'b0;
    localparam arb_state_t StBusy = 1'b1;

    localparam int unsigned ADR_W_DEF = 32;
    localparam int unsigned DAT_W_DEF = 32;
    localparam int unsigned SEL_W_DEF = 2;

    // Widest requester vector any arbiter built on rr_pick may use.
    localparam int unsigned MAX_M = 4;

    // Rotate a one-hot priority vector left by one place within its low n bits.
    function automatic logic [MAX_M-1:0] rotl_onehot(input logic [MAX_M-1:0] v, input int n);
        logic [MAX_M-1:0] r;
        r = '0;
        for (int i = 0; i < int'(MAX_M); i++) begin
            if (i < n) begin
                r[(i + 1) % n] = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after index last_i, wrapping.
// Reusable by any shared-resource arbiter with up to MAX_M requesters.
module rr_pick
    import wb_sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic             valid_o
);

    logic [MAX_M-1:0] prio;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        prio    = rotl_onehot(MAX_M'(1) << last_i, int'(NUM_M));
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (!valid_o && (|(prio[NUM_M-1:0] & req_i))) begin
                gnt_o   = prio[NUM_M-1:0];
                valid_o = 1'b1;
            end
            prio = rotl_onehot(prio, int'(NUM_M));
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Round-robin Wishbone classic arbiter in front of wb_sdram_ctrl, one transfer in flight.
// Define WB_SDRAM_ARB_TIMEOUT_EN to build the BUSY watchdog that errors a stuck transfer.
module wb_sdram_arbiter
    import wb_sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_M          = 2,
    parameter int unsigned ADR_W          = ADR_W_DEF,
    parameter int unsigned DAT_W          = DAT_W_DEF,
    parameter int unsigned SEL_W          = SEL_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NUM_M*ADR_W-1:0] m_adr_i,
    input  logic [NUM_M*DAT_W-1:0] m_dat_i,
    input  logic [NUM_M*SEL_W-1:0] m_sel_i,
    input  logic [NUM_M-1:0]       m_we_i,
    input  logic [NUM_M-1:0]       m_stb_i,
    output logic [DAT_W-1:0]       m_dat_o,
    output logic [NUM_M-1:0]       m_ack_o,
    output logic [NUM_M-1:0]       m_err_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [SEL_W-1:0]       s_sel_o,
    output logic                   s_we_o,
    output logic                   s_stb_o,
    input  logic [DAT_W-1:0]       s_dat_i,
    input  logic                   s_ack_i,
    output logic [NUM_M-1:0]       grant_o
);

    localparam int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             we_q, we_d;
    logic             stb_q, stb_d;
    logic [NUM_M-1:0] grant_q, grant_d;

    logic [NUM_M-1:0] pick_gnt;
    logic             pick_valid;
    logic [IDX_W-1:0] win_idx;
    logic [ADR_W-1:0] win_adr;
    logic [DAT_W-1:0] win_dat;
    logic [SEL_W-1:0] win_sel;
    logic             win_we;
    logic             busy;
    logic             timeout;

    assign busy = (state_q == StBusy);

    rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i   (m_stb_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        win_adr = '0;
        win_dat = '0;
        win_sel = '0;
        win_we  = 1'b0;
        for (int i = 0; i < int'(NUM_M); i++) begin
            if (pick_gnt[i]) begin
                win_idx = IDX_W'(i);
                win_adr = m_adr_i[i*ADR_W +: ADR_W];
                win_dat = m_dat_i[i*DAT_W +: DAT_W];
                win_sel = m_sel_i[i*SEL_W +: SEL_W];
                win_we  = m_we_i[i];
            end
        end
    end

`ifdef WB_SDRAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires during the TIMEOUT_CYCLES-th BUSY cycle without ack; an ack in that cycle wins.
    assign timeout = busy && !s_ack_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!s_ack_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign m_err_o = timeout ? grant_q : '0;
`else
    assign timeout = 1'b0;
    assign m_err_o = '0;
`endif

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        stb_d   = stb_q;
        grant_d = grant_q;
        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StBusy;
                    last_d  = win_idx;
                    adr_d   = win_adr;
                    dat_d   = win_dat;
                    sel_d   = win_sel;
                    we_d    = win_we;
                    stb_d   = 1'b1;
                    grant_d = pick_gnt;
                end
            end
            StBusy: begin
                // Requests seen in the ending cycle wait for IDLE and the updated pointer.
                if (s_ack_i || timeout) begin
                    state_d = StIdle;
                    stb_d   = 1'b0;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                stb_d   = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= StIdle;
            last_q  <= IDX_W'(NUM_M - 1);
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            grant_q <= grant_d;
        end
    end

    assign s_adr_o = adr_q;
    assign s_dat_o = dat_q;
    assign s_sel_o = sel_q;
    assign s_we_o  = we_q;
    assign s_stb_o = stb_q;
    assign grant_o = grant_q;
    assign m_ack_o = (s_ack_i && busy) ? grant_q : '0;
    assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter with two masters; the watchdog sequence
// runs only when WB_SDRAM_ARB_TIMEOUT_EN is defined.
module tb_wb_sdram_arbiter;

    localparam int unsigned NM = 2;
    localparam logic [31:0] A0 = 32'h0123_1234;
    localparam logic [31:0] A1 = 32'h0000_B0B0;
    localparam logic [31:0] D0 = 32'h1111_0000;
    localparam logic [31:0] D1 = 32'h2222_0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   m_adr;
    logic [63:0]   m_dat;
    logic [3:0]    m_sel;
    logic [1:0]    m_we;
    logic [1:0]    m_stb;
    logic [31:0]   m_dat_o;
    logic [1:0]    m_ack;
    logic [1:0]    m_err;
    logic [31:0]   s_adr;
    logic [31:0]   s_dat_o;
    logic [1:0]    s_sel;
    logic          s_we;
    logic          s_stb;
    logic [31:0]   s_dat_i;
    logic          s_ack;
    logic [1:0]    grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_sdram_arbiter #(
        .NUM_M          (NM),
        .ADR_W          (32),
        .DAT_W          (32),
        .SEL_W          (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_we_i   (m_we),
        .m_stb_i  (m_stb),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel),
        .s_we_o   (s_we),
        .s_stb_o  (s_stb),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack),
        .grant_o  (grant)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  stb;
        logic        sack;
        logic [31:0] sdat;
        logic        e_stb;
        logic [1:0]  e_gnt;
        logic [1:0]  e_ack;
        logic [31:0] e_adr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic r, logic [1:0] stb, logic sack, logic [31:0] sdat,
                                logic e_stb, logic [1:0] e_gnt, logic [1:0] e_ack,
                                logic [31:0] e_adr);
        vec_t v;
        v.rst = r; v.stb = stb; v.sack = sack; v.sdat = sdat;
        v.e_stb = e_stb; v.e_gnt = e_gnt; v.e_ack = e_ack; v.e_adr = e_adr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        m_adr   = {A1, A0};
        m_dat   = {D1, D0};
        m_sel   = 4'b1001;
        m_we    = 2'b00;
        m_stb   = 2'b00;
        s_dat_i = '0;
        s_ack   = 1'b0;
        tick();
        tick();

        // Single read, stray ack in IDLE, then reset and two-master contention.
        vq.push_back(mk(0, 2'b00, 0, 32'h0,        0, 2'b00, 2'b00, 32'h0));
        vq.push_back(mk(0, 2'b01, 0, 32'h0,        0, 2'b00, 2'b00, 32'h0));
        vq.push_back(mk(0, 2'b01, 0, 32'h0,        1, 2'b01, 2'b00, A0));
        vq.push_back(mk(0, 2'b01, 0, 32'h0,        1, 2'b01, 2'b00, A0));
        vq.push_back(mk(0, 2'b01, 0, 32'h0,        1, 2'b01, 2'b00, A0));
        vq.push_back(mk(0, 2'b01, 1, 32'hDEADBEEF, 1, 2'b01, 2'b01, A0));
        vq.push_back(mk(0, 2'b00, 0, 32'h0,        0, 2'b00, 2'b00, A0));
        vq.push_back(mk(0, 2'b00, 1, 32'h5A5A5A5A, 0, 2'b00, 2'b00, A0));
        vq.push_back(mk(0, 2'b00, 0, 32'h0,        0, 2'b00, 2'b00, A0));
        vq.push_back(mk(1, 2'b11, 0, 32'h0,        0, 2'b00, 2'b00, A0));
        vq.push_back(mk(0, 2'b11, 0, 32'h0,        0, 2'b00, 2'b00, 32'h0));
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  g;
            logic [31:0] a;
            g = k[0] ? 2'b10 : 2'b01;
            a = k[0] ? A1 : A0;
            vq.push_back(mk(0, 2'b11, 0, 32'h0,           1, g, 2'b00, a));
            vq.push_back(mk(0, 2'b11, 0, 32'h0,           1, g, 2'b00, a));
            vq.push_back(mk(0, 2'b11, 1, 32'hC0DE_0000 + 32'(k), 1, g, g, a));
            vq.push_back(mk(0, (k == 3) ? 2'b00 : 2'b11, 0, 32'h0, 0, 2'b00, 2'b00, a));
        end

        foreach (vq[i]) begin
            rst     = vq[i].rst;
            m_stb   = vq[i].stb;
            s_ack   = vq[i].sack;
            s_dat_i = vq[i].sdat;
            #2;
            chk($sformatf("v%0d s_stb", i), 32'(s_stb), 32'(vq[i].e_stb));
            chk($sformatf("v%0d grant", i), 32'(grant), 32'(vq[i].e_gnt));
            chk($sformatf("v%0d m_ack", i), 32'(m_ack), 32'(vq[i].e_ack));
            chk($sformatf("v%0d m_err", i), 32'(m_err), 32'h0);
            chk($sformatf("v%0d s_adr", i), s_adr, vq[i].e_adr);
            chk($sformatf("v%0d m_dat", i), m_dat_o, vq[i].sdat);
            tick();
        end
        rst = 1'b0; m_stb = 2'b00; s_ack = 1'b0; s_dat_i = '0;

        // Write latch: master 1 data changes after grant must not reach the slave.
        m_stb = 2'b10; m_we = 2'b10; m_dat = {32'hAAAA5555, D0}; m_sel = 4'b1101;
        tick();
        m_dat = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("wr s_dat", s_dat_o, 32'hAAAA5555);
            chk("wr s_we", 32'(s_we), 32'h1);
            chk("wr s_sel", 32'(s_sel), 32'h3);
            chk("wr grant", 32'(grant), 32'h2);
            tick();
        end
        s_ack = 1'b1;
        #2;
        chk("wr m_ack", 32'(m_ack), 32'h2);
        chk("wr s_dat at ack", s_dat_o, 32'hAAAA5555);
        tick();
        s_ack = 1'b0; m_stb = 2'b00; m_we = 2'b00; m_dat = {D1, D0}; m_sel = 4'b1001;
        #2;
        chk("wr s_stb after", 32'(s_stb), 32'h0);
        tick();

        // Early stb drop by the granted master: slave strobe holds until ack.
        m_stb = 2'b01;
        tick();
        m_stb = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("drop s_stb", 32'(s_stb), 32'h1);
            tick();
        end
        s_ack = 1'b1;
        #2;
        chk("drop m_ack", 32'(m_ack), 32'h1);
        tick();
        s_ack = 1'b0;
        #2;
        chk("drop s_stb after", 32'(s_stb), 32'h0);
        chk("drop grant after", 32'(grant), 32'h0);
        tick();

        // Reset in BUSY clears everything and restores master 0 priority.
        m_stb = 2'b10; m_we = 2'b10;
        tick();
        m_stb = 2'b00; m_we = 2'b00;
        #2;
        chk("rst pre s_stb", 32'(s_stb), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("rst s_stb", 32'(s_stb), 32'h0);
        chk("rst grant", 32'(grant), 32'h0);
        chk("rst s_adr", s_adr, 32'h0);
        chk("rst s_dat", s_dat_o, 32'h0);
        chk("rst s_sel", 32'(s_sel), 32'h0);
        chk("rst s_we", 32'(s_we), 32'h0);
        m_stb = 2'b11;
        tick();
        #2;
        chk("rst prio grant", 32'(grant), 32'h1);
        m_stb = 2'b00;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        tick();

`ifdef WB_SDRAM_ARB_TIMEOUT_EN
        // Watchdog: error pulse in the 8th BUSY cycle, then a late ack is ignored.
        m_stb = 2'b01;
        tick();
        for (int c = 1; c <= 8; c++) begin
            #2;
            chk($sformatf("to c%0d s_stb", c), 32'(s_stb), 32'h1);
            chk($sformatf("to c%0d m_err", c), 32'(m_err), (c == 8) ? 32'h1 : 32'h0);
            if (c == 8) m_stb = 2'b00;
            tick();
        end
        #2;
        chk("to s_stb after", 32'(s_stb), 32'h0);
        chk("to m_err after", 32'(m_err), 32'h0);
        s_ack = 1'b1;
        #2;
        chk("to late m_ack", 32'(m_ack), 32'h0);
        tick();
        s_ack = 1'b0;
        #2;
        chk("to idle grant", 32'(grant), 32'h0);
        chk("to idle s_stb", 32'(s_stb), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
